// File: rtl/dcpu_pkg.sv
// dcpu_pkg: shared definitions for the RV32I decode stage.
//   - XLEN / REG_AW datapath and register-address widths
//   - RV32I major opcode constants
//   - ex_op_e op-class enum presented to execute
//   - imm_fmt_e immediate-format enum and the immediate builder
//   - ex_bundle_t registered bundle handed to execute
package dcpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;
    localparam logic [6:0] OPC_MISC  = 7'b0001111;  // FENCE, folded into SYS

    typedef enum logic [3:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
        OP_LD, OP_ST, OP_OPI, OP_OP, OP_SYS
    } ex_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        ex_op_e            op;
        logic [2:0]        funct3;
        logic              alt;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              illegal;
    } ex_bundle_t;

    function automatic logic [31:0] build_imm(input imm_fmt_e fmt, input logic [31:0] i);
        case (fmt)
            IMM_I:   build_imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   build_imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   build_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   build_imm = {i[31:12], 12'b0};
            IMM_J:   build_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: build_imm = '0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_decoder.sv
// instr_decoder: purely combinational RV32I opcode classifier.
//   instr_i     in   32  instruction word
//   op_o        out  4   op class
//   imm_o       out  32  sign-extended immediate for the opcode's format
//   uses_rs1_o  out  1   rs1 is a source operand
//   uses_rs2_o  out  1   rs2 is a source operand
//   writes_rd_o out  1   instruction writes a non-zero rd
//   illegal_o   out  1   opcode outside RV32I
module instr_decoder
    import dcpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output ex_op_e      op_o,
    output logic [31:0] imm_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o,
    output logic        writes_rd_o,
    output logic        illegal_o
);

    imm_fmt_e fmt;
    logic     wr;

    always_comb begin
        op_o       = OP_LUI;
        fmt        = IMM_NONE;
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        wr         = 1'b0;
        illegal_o  = 1'b0;
        case (instr_i[6:0])
            OPC_LUI:   begin op_o = OP_LUI;   fmt = IMM_U; wr = 1'b1; end
            OPC_AUIPC: begin op_o = OP_AUIPC; fmt = IMM_U; wr = 1'b1; end
            OPC_JAL:   begin op_o = OP_JAL;   fmt = IMM_J; wr = 1'b1; end
            OPC_JALR:  begin op_o = OP_JALR;  fmt = IMM_I; uses_rs1_o = 1'b1; wr = 1'b1; end
            OPC_BR:    begin op_o = OP_BR;    fmt = IMM_B; uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; end
            OPC_LD:    begin op_o = OP_LD;    fmt = IMM_I; uses_rs1_o = 1'b1; wr = 1'b1; end
            OPC_ST:    begin op_o = OP_ST;    fmt = IMM_S; uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; end
            OPC_OPI:   begin op_o = OP_OPI;   fmt = IMM_I; uses_rs1_o = 1'b1; wr = 1'b1; end
            OPC_OP:    begin op_o = OP_OP;    uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; wr = 1'b1; end
            OPC_SYS,
            OPC_MISC:  begin op_o = OP_SYS;   fmt = IMM_I; uses_rs1_o = 1'b1; end
            default:   illegal_o = 1'b1;
        endcase
        imm_o       = build_imm(fmt, instr_i);
        // x0 writes are architectural no-ops: never track them in the scoreboard
        writes_rd_o = wr & (instr_i[11:7] != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode / operand-read stage between fetch and execute.
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_ready        fetch handshake; if_pc, if_instr presented instruction
//   rs_addr1/rs_addr2        register-file read addresses (combinational)
//   r_reg1/r_reg2            register-file read data (same cycle)
//   ex_valid/ex_ready        execute handshake for the registered bundle
//   ex_pc..ex_illegal        decoded bundle fields
//   wb_valid/wb_rd           writeback commit, clears the busy bit
//   flush                    kill the held bundle, block acceptance
module decode_stage
    import dcpu_pkg::*;
#(
    parameter int XLEN_P   = XLEN,
    parameter int REG_AW_P = REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [XLEN_P-1:0]   if_pc,
    input  logic [31:0]         if_instr,
    output logic [REG_AW_P-1:0] rs_addr1,
    output logic [REG_AW_P-1:0] rs_addr2,
    input  logic [XLEN_P-1:0]   r_reg1,
    input  logic [XLEN_P-1:0]   r_reg2,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [XLEN_P-1:0]   ex_pc,
    output logic [3:0]          ex_op,
    output logic [2:0]          ex_funct3,
    output logic                ex_alt,
    output logic [XLEN_P-1:0]   ex_rs1_val,
    output logic [XLEN_P-1:0]   ex_rs2_val,
    output logic [XLEN_P-1:0]   ex_imm,
    output logic [REG_AW_P-1:0] ex_rd,
    output logic                ex_wen,
    output logic                ex_illegal,
    input  logic                wb_valid,
    input  logic [REG_AW_P-1:0] wb_rd,
    input  logic                flush
);

    ex_op_e            dec_op;
    logic [31:0]       dec_imm;
    logic              uses_rs1, uses_rs2, writes_rd, illegal;
    logic [REG_AW-1:0] rd_w;
    logic              stall, accept;

    logic [NREGS-1:0]  busy_q, busy_d, busy_eff;
    ex_bundle_t        ex_q, ex_d;
    logic              ex_valid_q, ex_valid_d;

    instr_decoder u_dec (
        .instr_i     (if_instr),
        .op_o        (dec_op),
        .imm_o       (dec_imm),
        .uses_rs1_o  (uses_rs1),
        .uses_rs2_o  (uses_rs2),
        .writes_rd_o (writes_rd),
        .illegal_o   (illegal)
    );

    assign rs_addr1 = if_instr[19:15];
    assign rs_addr2 = if_instr[24:20];
    assign rd_w     = if_instr[11:7];

    // x0 never busy; stall is computed from registered busy only, so a
    // same-cycle writeback releases the stall one cycle later.
    assign busy_eff = {busy_q[NREGS-1:1], 1'b0};
    assign stall    = (uses_rs1 & busy_eff[rs_addr1]) |
                      (uses_rs2 & busy_eff[rs_addr2]) |
                      (writes_rd & busy_eff[rd_w]);
    assign if_ready = ~rst & ~flush & ~stall & (~ex_valid_q | ex_ready);
    assign accept   = if_valid & if_ready;

    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d     = 1'b1;
            ex_d.pc        = if_pc;
            ex_d.op        = dec_op;
            ex_d.funct3    = if_instr[14:12];
            ex_d.alt       = if_instr[30];
            ex_d.rs1_val   = uses_rs1 ? r_reg1 : '0;
            ex_d.rs2_val   = uses_rs2 ? r_reg2 : '0;
            ex_d.imm       = dec_imm;
            ex_d.rd        = rd_w;
            ex_d.wen       = writes_rd;
            ex_d.illegal   = illegal;
        end else if (ex_valid_q && ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_valid && wb_rd != '0)
            busy_d[wb_rd] = 1'b0;
        // the killed bundle was the only pending writer of its rd (WAW stall)
        if (flush && ex_valid_q && ex_q.wen)
            busy_d[ex_q.rd] = 1'b0;
        if (accept && writes_rd)
            busy_d[rd_w] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            busy_q     <= '0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
            busy_q     <= busy_d;
        end
    end

    // A writer can only be accepted for a register nobody else is writing back.
    always_ff @(posedge clk) begin
        if (!rst && accept && writes_rd)
            assert (!(wb_valid && wb_rd == rd_w));
    end

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_q.pc;
    assign ex_op      = ex_q.op;
    assign ex_funct3  = ex_q.funct3;
    assign ex_alt     = ex_q.alt;
    assign ex_rs1_val = ex_q.rs1_val;
    assign ex_rs2_val = ex_q.rs2_val;
    assign ex_imm     = ex_q.imm;
    assign ex_rd      = ex_q.rd;
    assign ex_wen     = ex_q.wen;
    assign ex_illegal = ex_q.illegal;

endmodule
